spi_target: RTL

- SPI peripheral-side (target) endpoint, the far end of the team's SPI initiator.
- Receives words from an external initiator on SCLK/MOSI while nSS is low, and returns words on MISO.
- Presents received words and accepts transmit words on a parallel, clk-domain interface for a local controller.
- Frame format matches the initiator: SCLK idles high, data changes on falling SCLK, data is sampled on rising SCLK.
- 8-bit (narrow) or 32-bit (wide) words, selected by the `wide` input.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_target.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word sizes, frame state, and the byte-rotating
// shift used by both ends of the link so that byte0 travels first.
package spi_pkg;

    localparam int NARROW_BITS = 8;
    localparam int WIDE_BITS   = 32;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Wide words behave as one 32-bit shift register ordered
    // [24..31],[16..23],[8..15],[0..7]: new bits enter at 24, exit from 7.
    function automatic logic [31:0] rot_shift(input logic [31:0] v,
                                              input logic        in,
                                              input logic        wide);
        if (wide)
            return {v[30:24], in, v[22:16], v[31], v[14:8], v[23], v[6:0], v[15]};
        else
            return {24'h0, v[6:0], in};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with registered-level
// edge detection on the last stage.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 so idle-high SPI lines produce no edge on reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: SCLK idles high, data changes on falling SCLK and is
// sampled on rising SCLK; 8- or 32-bit words, back-to-back within one nSS.
module spi_target
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wide,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        nSS,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [31:0] dataTx,
    output logic        txTaken,
    output logic [31:0] dataRx,
    output logic        rxValid,
    output logic        abort
);

    logic sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;
    logic unused_sclk_lvl, unused_nss_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(SCLK),
        .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nss (
        .clk(clk), .rst(rst), .d_i(nSS),
        .level_o(unused_nss_lvl), .rise_o(nss_rise), .fall_o(nss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(MOSI),
        .level_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    state_t      state_q;
    logic        wide_q, newword_q, seen_rise_q, oe_q;
    logic        rxvalid_q, txtaken_q, abort_q;
    logic [4:0]  bitcnt_q;
    logic [4:0]  last_bit;
    logic [31:0] rxsh_q, txsh_q, datarx_q;
    logic [31:0] rxsh_d, txsh_d;

    assign last_bit = wide_q ? 5'(WIDE_BITS - 1) : 5'(NARROW_BITS - 1);
    assign rxsh_d   = rot_shift(rxsh_q, mosi_s, wide_q);
    assign txsh_d   = rot_shift(txsh_q, 1'b1, wide_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wide_q      <= 1'b0;
            newword_q   <= 1'b0;
            seen_rise_q <= 1'b0;
            oe_q        <= 1'b0;
            rxvalid_q   <= 1'b0;
            txtaken_q   <= 1'b0;
            abort_q     <= 1'b0;
            bitcnt_q    <= '0;
            rxsh_q      <= '0;
            txsh_q      <= '1;
            datarx_q    <= '0;
        end else begin
            rxvalid_q <= 1'b0;
            txtaken_q <= 1'b0;
            abort_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (nss_fall) begin
                        state_q     <= ACTIVE;
                        wide_q      <= wide;
                        txsh_q      <= dataTx;
                        txtaken_q   <= 1'b1;
                        oe_q        <= 1'b1;
                        bitcnt_q    <= '0;
                        newword_q   <= 1'b0;
                        seen_rise_q <= 1'b0;
                        rxsh_q      <= '0;
                    end
                end
                ACTIVE: begin
                    // nSS release takes priority over any coincident SCLK edge.
                    if (nss_rise) begin
                        state_q  <= IDLE;
                        oe_q     <= 1'b0;
                        txsh_q   <= '1;
                        abort_q  <= (bitcnt_q != 5'd0);
                        bitcnt_q <= '0;
                    end else if (sclk_rise) begin
                        seen_rise_q <= 1'b1;
                        rxsh_q      <= rxsh_d;
                        if (bitcnt_q == last_bit) begin
                            datarx_q  <= rxsh_d;
                            rxvalid_q <= 1'b1;
                            bitcnt_q  <= '0;
                            newword_q <= 1'b1;
                        end else begin
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end else if (sclk_fall && seen_rise_q) begin
                        if (newword_q) begin
                            txsh_q    <= dataTx;
                            txtaken_q <= 1'b1;
                            newword_q <= 1'b0;
                        end else begin
                            txsh_q <= txsh_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MISO    = txsh_q[7];
    assign MISO_oe = oe_q;
    assign dataRx  = datarx_q;
    assign rxValid = rxvalid_q;
    assign txTaken = txtaken_q;
    assign abort   = abort_q;

endmodule
